// File: rtl/kmul_pkg.sv
// Shared width helpers for the Karatsuba multiplier pipeline.
// Stage payload structs are built from these helpers inside the top module.
package kmul_pkg;

    localparam int KMUL_CNT_W = 32;

    // Operand half-width H used for the Karatsuba split.
    function automatic int kmul_half_w(input int n);
        return n / 2;
    endfunction

    // Middle product (a+b)*(c+d): two (H+1)-bit sums give 2H+2 bits.
    function automatic int kmul_mid_w(input int n);
        return 2 * (n / 2) + 2;
    endfunction

    function automatic bit kmul_width_ok(input int n);
        return (n >= 4) && ((n % 2) == 0);
    endfunction

endpackage

// File: rtl/kmul_stage_reg.sv
// Generic pipeline register slice carrying a valid bit and an opaque payload.
// Latency: 1 cycle when load is high; contents held when load is low.
// Backpressure: owner computes load (!vld || downstream loads); slice just obeys it.
module kmul_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         nxt_vld,
    input  logic [W-1:0] nxt_dat,
    output logic         vld,
    output logic [W-1:0] dat
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (load) begin
            vld <= nxt_vld;
            dat <= nxt_dat;
        end
    end

endmodule

// File: rtl/karatsuba_mult_pipe.sv
// Three-stage Karatsuba multiplier, signed/unsigned per transaction, ID tag carried along.
// Latency: 3 cycles from accept to out_valid; one operand pair per cycle sustained.
// Backpressure: stalls hold every stage; in_ready is the S1 load term. KMUL_CNT_EN adds done/stall counters.
module karatsuba_mult_pipe
    import kmul_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_a,
    input  logic [DATA_WIDTH-1:0]   in_b,
    input  logic                    in_signed,
    input  logic [ID_WIDTH-1:0]     in_id,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_product,
    output logic [ID_WIDTH-1:0]     out_id
`ifdef KMUL_CNT_EN
    ,
    output logic [KMUL_CNT_W-1:0]   done_cnt,
    output logic [KMUL_CNT_W-1:0]   stall_cnt
`endif
);

    localparam int N  = DATA_WIDTH;
    localparam int H  = kmul_half_w(DATA_WIDTH);
    localparam int MW = kmul_mid_w(DATA_WIDTH);

    generate
        if (!kmul_width_ok(DATA_WIDTH)) begin : g_bad_width
            $error("karatsuba_mult_pipe: DATA_WIDTH must be even and >= 4");
        end
    endgenerate

    typedef struct packed {
        logic [N-1:0]        mag_a;
        logic [N-1:0]        mag_b;
        logic                neg;
        logic [ID_WIDTH-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [2*H-1:0]      ac;
        logic [2*H-1:0]      bd;
        logic [MW-1:0]       m;
        logic                neg;
        logic [ID_WIDTH-1:0] id;
    } s2_t;

    typedef struct packed {
        logic [2*N-1:0]      product;
        logic [ID_WIDTH-1:0] id;
    } s3_t;

    logic s1_vld, s2_vld, s3_vld;
    logic s1_load, s2_load, s3_load;
    s1_t  s1_nxt, s1_q;
    s2_t  s2_nxt, s2_q;
    s3_t  s3_nxt, s3_q;

    // Load chain runs from the output back to the input so a draining consumer
    // frees every stage in the same cycle.
    assign s3_load  = !s3_vld || out_ready;
    assign s2_load  = !s2_vld || s3_load;
    assign s1_load  = !s1_vld || s2_load;
    assign in_ready = s1_load;

    // S1: sign-magnitude conversion; -2^(N-1) maps to 2^(N-1), which fits N unsigned bits.
    logic a_neg, b_neg;

    always_comb begin
        a_neg         = in_signed & in_a[N-1];
        b_neg         = in_signed & in_b[N-1];
        s1_nxt        = '0;
        s1_nxt.mag_a  = a_neg ? (~in_a + 1'b1) : in_a;
        s1_nxt.mag_b  = b_neg ? (~in_b + 1'b1) : in_b;
        s1_nxt.neg    = in_signed & (in_a[N-1] ^ in_b[N-1]);
        s1_nxt.id     = in_id;
    end

    kmul_stage_reg #(.W($bits(s1_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (s1_load),
        .nxt_vld (in_valid),
        .nxt_dat (s1_nxt),
        .vld     (s1_vld),
        .dat     (s1_q)
    );

    // S2: three half-width products instead of four.
    logic [2*H-1:0] a_w, b_w, c_w, d_w;
    logic [MW-1:0]  sum_ab, sum_cd;

    always_comb begin
        a_w        = {{H{1'b0}}, s1_q.mag_a[N-1:H]};
        b_w        = {{H{1'b0}}, s1_q.mag_a[H-1:0]};
        c_w        = {{H{1'b0}}, s1_q.mag_b[N-1:H]};
        d_w        = {{H{1'b0}}, s1_q.mag_b[H-1:0]};
        sum_ab     = {{(MW-H){1'b0}}, s1_q.mag_a[N-1:H]} + {{(MW-H){1'b0}}, s1_q.mag_a[H-1:0]};
        sum_cd     = {{(MW-H){1'b0}}, s1_q.mag_b[N-1:H]} + {{(MW-H){1'b0}}, s1_q.mag_b[H-1:0]};
        s2_nxt     = '0;
        s2_nxt.ac  = a_w * c_w;
        s2_nxt.bd  = b_w * d_w;
        s2_nxt.m   = sum_ab * sum_cd;
        s2_nxt.neg = s1_q.neg;
        s2_nxt.id  = s1_q.id;
    end

    kmul_stage_reg #(.W($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (s2_load),
        .nxt_vld (s1_vld),
        .nxt_dat (s2_nxt),
        .vld     (s2_vld),
        .dat     (s2_q)
    );

    // S3: recombine; m - ac - bd = ad + bc is never negative, so 2N-bit wrap is safe.
    logic [2*N-1:0] ac_x, bd_x, m_x, mid_x, mag_p;

    always_comb begin
        ac_x           = {{(2*N-2*H){1'b0}}, s2_q.ac};
        bd_x           = {{(2*N-2*H){1'b0}}, s2_q.bd};
        m_x            = {{(2*N-MW){1'b0}}, s2_q.m};
        mid_x          = m_x - ac_x - bd_x;
        mag_p          = (ac_x << N) + (mid_x << H) + bd_x;
        s3_nxt         = '0;
        s3_nxt.product = s2_q.neg ? (~mag_p + 1'b1) : mag_p;
        s3_nxt.id      = s2_q.id;
    end

    kmul_stage_reg #(.W($bits(s3_t))) u_s3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (s3_load),
        .nxt_vld (s2_vld),
        .nxt_dat (s3_nxt),
        .vld     (s3_vld),
        .dat     (s3_q)
    );

    assign out_valid   = s3_vld;
    assign out_product = s3_q.product;
    assign out_id      = s3_q.id;

`ifdef KMUL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (s3_vld && out_ready) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (s3_vld && !out_ready) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
